// File: rtl/note_scroller.sv
// note_scroller
// Falling-note scheduler placed in front of the VGA sprite writer. It keeps a
// table of up to SLOTS notes. Software spawns notes and reports hits. On every
// frame_tick the block sweeps the table once: each active note moves down by
// `speed` pixels, notes that leave the playfield are retired as misses, and one
// 32-bit sprite packet is streamed out per changed slot. Packets use the same
// layout as the sprite register word, so the sprite RAM is refreshed without
// the CPU.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse at the start of vertical blank
//   speed[3:0]          pixels per frame, captured when a sweep starts
//   spawn_valid/ready   spawn handshake; spawn_id[5:0], spawn_x[9:0] give the note
//   hit_valid           one-cycle pulse removing the note in hit_index[5:0]
//   pkt_valid/ready     packet handshake; pkt_data = {index, id, y, x}
//   busy                sweep in progress
//   missed              one-cycle pulse per retired note
//   missed_count[15:0]  saturating count of retired notes
//   frame_overrun       sticky, set when frame_tick arrives mid-sweep
module note_scroller #(
  parameter int SLOTS   = 64,
  parameter int Y_LIMIT = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [3:0]  speed,
  input  logic        spawn_valid,
  output logic        spawn_ready,
  input  logic [5:0]  spawn_id,
  input  logic [9:0]  spawn_x,
  input  logic        hit_valid,
  input  logic [5:0]  hit_index,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [31:0] pkt_data,
  output logic        busy,
  output logic        missed,
  output logic [15:0] missed_count,
  output logic        frame_overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  localparam logic [5:0]  LAST_SLOT = 6'(SLOTS - 1);
  localparam logic [10:0] Y_LIM     = 11'(Y_LIMIT);

  state_t state, next_state;

  // Note table
  logic [SLOTS-1:0] active;
  logic [SLOTS-1:0] pending_clear;
  logic [5:0]       id_mem [SLOTS];
  logic [9:0]       x_mem  [SLOTS];
  logic [9:0]       y_mem  [SLOTS];

  logic [5:0]  ptr;
  logic [3:0]  speed_q;

  logic        free_found;
  logic [5:0]  free_idx;
  logic        spawn_fire;
  logic        hit_ok;
  logic        hit_here;

  logic [5:0]  cur_id;
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;
  logic [10:0] sum;

  logic        scan_emit;
  logic        scan_retire;
  logic        scan_move;
  logic        scan_clear;
  logic [31:0] scan_pkt;

  // Lowest-index inactive slot; scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = 6'(i);
      end
    end
  end

  assign spawn_ready = (state == IDLE) && free_found;
  assign spawn_fire  = spawn_valid && spawn_ready;

  // Indices beyond the table are ignored when SLOTS is below 64.
  assign hit_ok   = hit_valid && ({26'd0, hit_index} < 32'(SLOTS));
  assign hit_here = hit_ok && (hit_index == ptr);

  // Decide what the slot under the pointer does during SCAN. A hit landing on
  // the slot being scanned takes priority and turns it into a clear packet.
  always_comb begin
    cur_id      = id_mem[ptr];
    cur_x       = x_mem[ptr];
    cur_y       = y_mem[ptr];
    sum         = {1'b0, cur_y} + {7'd0, speed_q};
    scan_emit   = 1'b0;
    scan_retire = 1'b0;
    scan_move   = 1'b0;
    scan_pkt    = '0;
    if (state == SCAN) begin
      if (hit_here) begin
        scan_emit = 1'b1;
        scan_pkt  = {ptr, 6'd0, cur_y, cur_x};
      end else if (active[ptr]) begin
        scan_emit = 1'b1;
        if (sum >= Y_LIM) begin
          scan_retire = 1'b1;
          scan_pkt    = {ptr, 6'd0, cur_y, cur_x};
        end else begin
          scan_move = 1'b1;
          scan_pkt  = {ptr, cur_id, sum[9:0], cur_x};
        end
      end else if (pending_clear[ptr]) begin
        scan_emit = 1'b1;
        scan_pkt  = {ptr, 6'd0, cur_y, cur_x};
      end
    end
  end

  assign scan_clear = scan_emit && !scan_retire && !scan_move;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (frame_tick) next_state = SCAN;
      SCAN: begin
        if (scan_emit) begin
          next_state = EMIT;
        end else if (ptr == LAST_SLOT) begin
          next_state = IDLE;
        end
      end
      EMIT: begin
        if (pkt_ready) begin
          next_state = (ptr == LAST_SLOT) ? IDLE : SCAN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    pkt_valid = (state == EMIT);
    busy      = (state != IDLE);
  end

  // Table update. Later statements override earlier ones: a hit beats the
  // scan result, a hit on the slot being scanned still leaves pending_clear
  // low because its clear packet is already going out, and a spawn beats a
  // hit on the same slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active        <= '0;
      pending_clear <= '1;
      for (int i = 0; i < SLOTS; i++) begin
        id_mem[i] <= '0;
        x_mem[i]  <= '0;
        y_mem[i]  <= '0;
      end
    end else begin
      if (scan_retire) begin
        active[ptr] <= 1'b0;
      end
      if (scan_move) begin
        y_mem[ptr] <= sum[9:0];
      end
      if (hit_ok) begin
        active[hit_index]        <= 1'b0;
        pending_clear[hit_index] <= 1'b1;
      end
      if (scan_clear) begin
        pending_clear[ptr] <= 1'b0;
      end
      if (spawn_fire) begin
        active[free_idx]        <= 1'b1;
        pending_clear[free_idx] <= 1'b0;
        id_mem[free_idx]        <= spawn_id;
        x_mem[free_idx]         <= spawn_x;
        y_mem[free_idx]         <= '0;
      end
    end
  end

  // Sweep bookkeeping, packet register and miss/overrun status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= '0;
      speed_q       <= '0;
      pkt_data      <= '0;
      missed        <= 1'b0;
      missed_count  <= '0;
      frame_overrun <= 1'b0;
    end else begin
      missed <= scan_retire;
      if (scan_retire && (missed_count != 16'hFFFF)) begin
        missed_count <= missed_count + 16'd1;
      end
      if (frame_tick && (state != IDLE)) begin
        frame_overrun <= 1'b1;
      end
      if ((state == IDLE) && frame_tick) begin
        speed_q <= speed;
        ptr     <= '0;
      end
      if (scan_emit) begin
        pkt_data <= scan_pkt;
      end
      if (((state == SCAN) && !scan_emit) || ((state == EMIT) && pkt_ready)) begin
        if (ptr != LAST_SLOT) begin
          ptr <= ptr + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
// Directed testbench for note_scroller. Expected packets are queued before each
// sweep starts, and a monitor pops and compares one entry per packet handshake.
module tb_note_scroller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [3:0]  speed;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [5:0]  spawn_id;
  logic [9:0]  spawn_x;
  logic        hit_valid;
  logic [5:0]  hit_index;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pkt_data;
  logic        busy;
  logic        missed;
  logic [15:0] missed_count;
  logic        frame_overrun;

  int checks = 0;
  int errors = 0;
  int missed_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pkt;

  // Reference view of the note table
  bit         m_active [64];
  bit         m_pend   [64];
  logic [5:0] m_id     [64];
  logic [9:0] m_x      [64];
  logic [9:0] m_y      [64];
  int         m_missed = 0;

  note_scroller dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .speed(speed),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_id(spawn_id),
    .spawn_x(spawn_x), .hit_valid(hit_valid), .hit_index(hit_index),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .busy(busy), .missed(missed), .missed_count(missed_count),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Packet scoreboard and miss-pulse alignment
  always @(negedge clk) begin
    if (reset_n && pkt_valid && pkt_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("pkt_unexpected", 32'(pkt_valid), 32'd0);
      end else begin
        exp_pkt = exp_q.pop_front();
        checkOutput("pkt_data", pkt_data, exp_pkt);
      end
    end
    if (reset_n && missed) begin
      missed_seen++;
      checkOutput("missed_with_pkt_valid", 32'(pkt_valid), 32'd1);
      checkOutput("missed_pkt_id", 32'(pkt_data[25:20]), 32'd0);
    end
  end

  task automatic reset_model();
    for (int i = 0; i < 64; i++) begin
      m_active[i] = 1'b0;
      m_pend[i]   = 1'b1;
      m_id[i]     = '0;
      m_x[i]      = '0;
      m_y[i]      = '0;
    end
    m_missed = 0;
  endtask

  // Queue the packets one sweep should produce and advance the reference table.
  task automatic expect_sweep(input logic [3:0] spd);
    logic [10:0] s;
    for (int i = 0; i < 64; i++) begin
      if (m_active[i]) begin
        s = {1'b0, m_y[i]} + {7'd0, spd};
        if (s >= 11'd480) begin
          m_active[i] = 1'b0;
          m_missed++;
          exp_q.push_back({6'(i), 6'd0, m_y[i], m_x[i]});
        end else begin
          m_y[i] = s[9:0];
          exp_q.push_back({6'(i), m_id[i], m_y[i], m_x[i]});
        end
      end else if (m_pend[i]) begin
        m_pend[i] = 1'b0;
        exp_q.push_back({6'(i), 6'd0, m_y[i], m_x[i]});
      end
    end
  endtask

  task automatic spawnNote(input logic [5:0] id, input logic [9:0] x, input int slot);
    @(posedge clk); #1;
    spawn_valid = 1'b1;
    spawn_id    = id;
    spawn_x     = x;
    @(negedge clk);
    checkOutput("spawn_ready", 32'(spawn_ready), 32'd1);
    @(posedge clk); #1;
    spawn_valid = 1'b0;
    m_active[slot] = 1'b1;
    m_pend[slot]   = 1'b0;
    m_id[slot]     = id;
    m_x[slot]      = x;
    m_y[slot]      = '0;
  endtask

  // Run one sweep; optionally pulse a hit during negedge-cycle hit_at after the
  // sweep starts (cycle 0 is the SCAN of slot 0).
  task automatic applyStimulus(input logic [3:0] spd, input int hit_at,
                               input logic [5:0] hit_slot, output int busy_cycles);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    speed      = spd;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick  = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (c == hit_at) begin
        hit_valid = 1'b1;
        hit_index = hit_slot;
      end else if (c == hit_at + 1) begin
        hit_valid = 1'b0;
      end
      if (busy) busy_cycles++;
      else done = 1'b1;
    end
    checkOutput("sweep_finished", 32'(busy), 32'd0);
    checkOutput("sweep_pkts_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int  bc;
    bit  seen;
    reset_n     = 1'b0;
    frame_tick  = 1'b0;
    speed       = '0;
    spawn_valid = 1'b0;
    spawn_id    = '0;
    spawn_x     = '0;
    hit_valid   = 1'b0;
    hit_index   = '0;
    pkt_ready   = 1'b1;
    reset_model();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    checkOutput("rst_pkt_data", pkt_data, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_missed", 32'(missed), 32'd0);
    checkOutput("rst_missed_count", 32'(missed_count), 32'd0);
    checkOutput("rst_overrun", 32'(frame_overrun), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_spawn_ready", 32'(spawn_ready), 32'd1);

    // First sweep blanks every slot: 64 packets, 128 busy cycles
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({6'(i), 26'd0});
      m_pend[i] = 1'b0;
    end
    applyStimulus(4'd0, -1, 6'd0, bc);
    checkOutput("reset_sweep_busy_cycles", 32'(bc), 32'd128);
    checkOutput("reset_sweep_no_miss", 32'(missed_seen), 32'd0);

    // Spawn id 5 at x 100, two frames at speed 3
    spawnNote(6'd5, 10'd100, 0);
    exp_q.push_back(32'h00500C64);
    applyStimulus(4'd3, -1, 6'd0, bc);
    exp_q.push_back(32'h00501864);
    applyStimulus(4'd3, -1, 6'd0, bc);
    m_y[0] = 10'd6;

    // Drive the note down to y=478, then retire it with speed 2
    for (int k = 0; k < 31; k++) begin
      expect_sweep(4'd15);
      applyStimulus(4'd15, -1, 6'd0, bc);
    end
    expect_sweep(4'd7);
    applyStimulus(4'd7, -1, 6'd0, bc);
    exp_q.push_back({6'd0, 6'd0, 10'd478, 10'd100});
    m_active[0] = 1'b0;
    m_missed    = 1;
    applyStimulus(4'd2, -1, 6'd0, bc);
    checkOutput("miss_pulses", 32'(missed_seen), 32'(m_missed));
    checkOutput("miss_count", 32'(missed_count), 32'(m_missed));
    checkOutput("miss_spawn_ready", 32'(spawn_ready), 32'd1);

    // Hit on slot 2 during its own SCAN cycle
    spawnNote(6'd7, 10'd200, 0);
    spawnNote(6'd8, 10'd300, 1);
    spawnNote(6'd9, 10'd400, 2);
    m_active[2] = 1'b0;
    m_pend[2]   = 1'b1;
    expect_sweep(4'd4);
    applyStimulus(4'd4, 4, 6'd2, bc);
    checkOutput("hit_scan_no_miss", 32'(missed_count), 32'(m_missed));
    expect_sweep(4'd4);
    applyStimulus(4'd4, -1, 6'd0, bc);

    // Stalled sweep with a dropped frame_tick
    pkt_ready = 1'b0;
    expect_sweep(4'd1);
    @(posedge clk); #1;
    speed      = 4'd1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = pkt_valid;
    end
    checkOutput("stall_valid_seen", 32'(pkt_valid), 32'd1);
    checkOutput("sweep_spawn_refused", 32'(spawn_ready), 32'd0);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) frame_tick = 1'b1;
      else if (c == 6) frame_tick = 1'b0;
      checkOutput("stall_data", pkt_data, (exp_q.size() > 0) ? exp_q[0] : 32'hDEADBEEF);
      checkOutput("stall_valid", 32'(pkt_valid), 32'd1);
      @(negedge clk);
    end
    checkOutput("overrun_set", 32'(frame_overrun), 32'd1);
    pkt_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = !busy;
    end
    checkOutput("stall_sweep_done", 32'(busy), 32'd0);
    checkOutput("stall_pkts_left", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("no_extra_sweep", 32'(busy), 32'd0);
    checkOutput("overrun_sticky", 32'(frame_overrun), 32'd1);

    // Reset in the middle of a sweep
    pkt_ready = 1'b0;
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = pkt_valid;
    end
    checkOutput("midrst_valid_seen", 32'(pkt_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_overrun", 32'(frame_overrun), 32'd0);
    checkOutput("midrst_missed_count", 32'(missed_count), 32'd0);
    reset_model();
    exp_q.delete();
    @(posedge clk); #1;
    reset_n   = 1'b1;
    pkt_ready = 1'b1;

    // Fill all 64 slots, free slot 10, refill it
    for (int k = 0; k < 64; k++) begin
      spawnNote(6'(k + 1), 10'(k * 7), k);
    end
    @(negedge clk);
    checkOutput("full_spawn_ready", 32'(spawn_ready), 32'd0);
    @(posedge clk); #1;
    hit_valid = 1'b1;
    hit_index = 6'd10;
    @(posedge clk); #1;
    hit_valid   = 1'b0;
    m_active[10] = 1'b0;
    m_pend[10]   = 1'b1;
    @(negedge clk);
    checkOutput("freed_spawn_ready", 32'(spawn_ready), 32'd1);
    spawnNote(6'd42, 10'd555, 10);
    expect_sweep(4'd1);
    applyStimulus(4'd1, -1, 6'd0, bc);
    checkOutput("full_sweep_busy_cycles", 32'(bc), 32'd128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
